// File: rtl/reg_file_pkg.sv
// Shared types and helpers for the multi-port register file.
// The priority-select function is shared by the write-commit and bypass logic.
package reg_file_pkg;

    typedef enum logic {
        CLEAR = 1'b0,
        IDLE  = 1'b1
    } state_e;

    // Ceiling on port count and address width handled by prio_sel.
    // Narrower callers zero-extend their vectors up to these widths.
    localparam int MAX_WR   = 8;
    localparam int MAX_AB   = 16;
    localparam int IDX_BITS = $clog2(MAX_WR);

    typedef struct packed {
        logic                valid;
        logic [IDX_BITS-1:0] idx;
    } wr_sel_t;

    // Highest-index enabled port whose address equals addr.
    // The ascending scan lets later hits overwrite earlier ones.
    function automatic wr_sel_t prio_sel(
        input logic [MAX_WR-1:0]             wen,
        input logic [MAX_WR-1:0][MAX_AB-1:0] wa,
        input logic [MAX_AB-1:0]             addr
    );
        wr_sel_t sel;
        sel = '0;
        for (int p = 0; p < MAX_WR; p++) begin
            if (wen[p] && (wa[p] == addr)) begin
                sel.valid = 1'b1;
                sel.idx   = IDX_BITS'(p);
            end
        end
        return sel;
    endfunction

endpackage

// File: rtl/reg_file_mp_if.sv
// Bundles the read/write port signals of reg_file_mp.
// The master side drives the ports; the register file is the slave.
interface reg_file_mp_if #(
    parameter int ADDR_BITS = 6,
    parameter int BITS      = 32,
    parameter int NUM_RD    = 2,
    parameter int NUM_WR    = 2
);

    logic                             clr_i;
    logic [NUM_WR-1:0]                wen_i;
    logic [NUM_WR-1:0][ADDR_BITS-1:0] wa_i;
    logic [NUM_WR-1:0][BITS-1:0]      wd_i;
    logic [NUM_RD-1:0][ADDR_BITS-1:0] ra_i;
    logic [NUM_RD-1:0][BITS-1:0]      rd_o;
    logic                             busy_o;
    logic                             wr_conflict_o;

    modport master (
        output clr_i, wen_i, wa_i, wd_i, ra_i,
        input  rd_o, busy_o, wr_conflict_o
    );

    modport slave (
        input  clr_i, wen_i, wa_i, wd_i, ra_i,
        output rd_o, busy_o, wr_conflict_o
    );

endinterface

// File: rtl/reg_file_clear_fsm.sv
// Clear sequencer: walks every entry writing zero after reset or on request,
// then parks in IDLE until the next clear request.
module reg_file_clear_fsm
    import reg_file_pkg::*;
#(
    parameter int ADDR_BITS = 6
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clr,
    output logic                 busy,
    output logic                 clr_we,
    output logic [ADDR_BITS-1:0] clr_addr
);

    state_e               state, state_nxt;
    logic [ADDR_BITS-1:0] cnt, cnt_nxt;

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge value of every other register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= CLEAR;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // NOTE: every combinational output gets a default before the case so no
    // path can leave it unassigned and infer a latch.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        unique case (state)
            CLEAR: begin
                cnt_nxt = cnt + 1'b1;
                if (&cnt) begin
                    state_nxt = IDLE;
                end
            end
            IDLE: begin
                if (clr) begin
                    state_nxt = CLEAR;
                    cnt_nxt   = '0;
                end
            end
            default: begin
                state_nxt = CLEAR;
                cnt_nxt   = '0;
            end
        endcase
    end

    always_comb begin
        busy     = (state == CLEAR);
        clr_we   = (state == CLEAR);
        clr_addr = cnt;
    end

endmodule

// File: rtl/reg_file_mp.sv
// Multi-port register file with prioritised writes, optional write-to-read
// bypass, optional hardwired zero entry and a hardware clear sequencer.
module reg_file_mp
    import reg_file_pkg::*;
#(
    parameter int ADDR_BITS = 6,
    parameter int BITS      = 32,
    parameter int NUM_RD    = 2,
    parameter int NUM_WR    = 2,
    parameter int ZERO_REG  = 1,
    parameter int BYPASS    = 1
) (
    input  logic         clk,
    input  logic         rst,
    reg_file_mp_if.slave bus
);

    localparam int DEPTH = 1 << ADDR_BITS;

    logic                 busy;
    logic                 clr_we;
    logic [ADDR_BITS-1:0] clr_addr;

    reg_file_clear_fsm #(
        .ADDR_BITS (ADDR_BITS)
    ) u_clear_fsm (
        .clk      (clk),
        .rst      (rst),
        .clr      (bus.clr_i),
        .busy     (busy),
        .clr_we   (clr_we),
        .clr_addr (clr_addr)
    );

    // Effective enables: nothing is accepted while clearing, and writes to
    // the zero entry are dropped before they can win, bypass or conflict.
    logic [MAX_WR-1:0]             wen_x;
    logic [MAX_WR-1:0][MAX_AB-1:0] wa_x;

    always_comb begin
        wen_x = '0;
        wa_x  = '0;
        for (int p = 0; p < NUM_WR; p++) begin
            wa_x[p]  = MAX_AB'(bus.wa_i[p]);
            wen_x[p] = bus.wen_i[p] && !busy &&
                       !((ZERO_REG != 0) && (bus.wa_i[p] == '0));
        end
    end

    // A port commits only if it is the priority winner for its own address,
    // so the committing ports always target distinct entries.
    logic [NUM_WR-1:0] win;

    always_comb begin
        wr_sel_t sel;
        sel = '0;
        win = '0;
        for (int p = 0; p < NUM_WR; p++) begin
            sel    = prio_sel(wen_x, wa_x, wa_x[p]);
            win[p] = wen_x[p] && (sel.idx == IDX_BITS'(p));
        end
    end

    // An enabled port that lost arbitration implies a shared address.
    logic conflict_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            conflict_q <= 1'b0;
        end else begin
            conflict_q <= |(wen_x[NUM_WR-1:0] & ~win);
        end
    end

    logic [BITS-1:0] mem [DEPTH];

    // NOTE: the storage array has no reset branch; the clear sequencer zeroes
    // it one entry per cycle, which keeps it mappable to plain RAM/flops.
    always_ff @(posedge clk) begin
        if (clr_we) begin
            mem[clr_addr] <= '0;
        end else begin
            for (int p = 0; p < NUM_WR; p++) begin
                if (win[p]) begin
                    mem[bus.wa_i[p]] <= bus.wd_i[p];
                end
            end
        end
    end

    logic [NUM_RD-1:0][BITS-1:0] rd;

    always_comb begin
        wr_sel_t sel;
        sel = '0;
        rd  = '0;
        for (int r = 0; r < NUM_RD; r++) begin
            sel = prio_sel(wen_x, wa_x, MAX_AB'(bus.ra_i[r]));
            if (!busy && !((ZERO_REG != 0) && (bus.ra_i[r] == '0))) begin
                rd[r] = mem[bus.ra_i[r]];
                if ((BYPASS != 0) && sel.valid) begin
                    for (int p = 0; p < NUM_WR; p++) begin
                        if (sel.idx == IDX_BITS'(p)) begin
                            rd[r] = bus.wd_i[p];
                        end
                    end
                end
            end
        end
    end

    assign bus.rd_o          = rd;
    assign bus.busy_o        = busy;
    assign bus.wr_conflict_o = conflict_q;

endmodule

// File: tb/tb_reg_file_mp.sv
// Self-checking bench for reg_file_mp: directed scenarios plus random traffic,
// all compared against an array-based reference model.
module tb_reg_file_mp;

    localparam int AB    = 6;
    localparam int W     = 32;
    localparam int NR    = 2;
    localparam int NW    = 2;
    localparam int DEPTH = 1 << AB;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    reg_file_mp_if #(.ADDR_BITS(AB), .BITS(W), .NUM_RD(NR), .NUM_WR(NW)) bus ();

    reg_file_mp #(
        .ADDR_BITS (AB),
        .BITS      (W),
        .NUM_RD    (NR),
        .NUM_WR    (NW),
        .ZERO_REG  (1),
        .BYPASS    (1)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_vectors     = 0;
    int n_miscompares = 0;

    // Reference model: contents, cycles of clearing still to go, and the
    // conflict flag expected in the current cycle.
    logic [W-1:0] mem_m [DEPTH];
    int           clear_left;
    logic         conf_m;

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_vectors++;
        if (got !== exp) begin
            n_miscompares++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [W-1:0] exp_read(input int r);
        if (clear_left > 0) return '0;
        if (bus.ra_i[r] == '0) return '0;
        for (int p = NW - 1; p >= 0; p--) begin
            if (bus.wen_i[p] && bus.wa_i[p] == bus.ra_i[r]) return bus.wd_i[p];
        end
        return mem_m[bus.ra_i[r]];
    endfunction

    task automatic zero_model();
        for (int i = 0; i < DEPTH; i++) mem_m[i] = '0;
    endtask

    task automatic model_update();
        if (rst) begin
            clear_left = DEPTH;
            conf_m     = 1'b0;
            zero_model();
        end else if (clear_left > 0) begin
            clear_left--;
            conf_m = 1'b0;
        end else begin
            conf_m = 1'b0;
            for (int p = 0; p < NW; p++) begin
                if (bus.wen_i[p] && bus.wa_i[p] != '0) mem_m[bus.wa_i[p]] = bus.wd_i[p];
            end
            for (int p = 0; p < NW; p++) begin
                for (int q = p + 1; q < NW; q++) begin
                    if (bus.wen_i[p] && bus.wen_i[q] && bus.wa_i[p] == bus.wa_i[q] && bus.wa_i[p] != '0)
                        conf_m = 1'b1;
                end
            end
            if (bus.clr_i) begin
                clear_left = DEPTH;
                zero_model();
            end
        end
    endtask

    // One clock: check all outputs at the falling edge, advance model at the rising edge.
    task automatic tick();
        @(negedge clk);
        for (int r = 0; r < NR; r++)
            check($sformatf("rd%0d@%0d", r, bus.ra_i[r]), bus.rd_o[r], exp_read(r));
        check("busy", W'(bus.busy_o), W'(clear_left > 0));
        check("conflict", W'(bus.wr_conflict_o), W'(conf_m));
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic quiet();
        bus.clr_i = 1'b0;
        bus.wen_i = '0;
        bus.wa_i  = '0;
        bus.wd_i  = '0;
        bus.ra_i  = '0;
    endtask

    task automatic rand_inputs(input bit allow_clr);
        for (int p = 0; p < NW; p++) begin
            bus.wen_i[p] = 1'($urandom);
            bus.wa_i[p]  = ($urandom_range(0, 1) == 0) ? AB'($urandom_range(0, 7)) : AB'($urandom);
            bus.wd_i[p]  = $urandom;
        end
        for (int r = 0; r < NR; r++)
            bus.ra_i[r] = ($urandom_range(0, 1) == 0) ? AB'($urandom_range(0, 7)) : AB'($urandom);
        bus.clr_i = allow_clr && ($urandom_range(0, 99) == 0);
    endtask

    // Count busy cycles from now, with random writes that must be dropped.
    task automatic measure_busy(input string tag);
        int len;
        len = 0;
        while (bus.busy_o === 1'b1 && len < 200) begin
            rand_inputs(1'b0);
            tick();
            len++;
        end
        quiet();
        check(tag, W'(len), W'(DEPTH));
    endtask

    initial begin
        quiet();
        rst = 1'b1;
        @(posedge clk);
        #1;
        clear_left = DEPTH;
        conf_m     = 1'b0;
        zero_model();

        // Reset held three cycles, then the power-up clear.
        tick();
        tick();
        rst = 1'b0;
        measure_busy("reset_busy_len");

        for (int a = 0; a < DEPTH / 2; a++) begin
            bus.ra_i[0] = AB'(2 * a);
            bus.ra_i[1] = AB'(2 * a + 1);
            tick();
        end

        // Same-cycle bypass, then hold.
        bus.wen_i[0] = 1'b1;
        bus.wa_i[0]  = 6'd5;
        bus.wd_i[0]  = 32'hDEADBEEF;
        bus.ra_i[0]  = 6'd5;
        #1;
        check("bypass_r5", bus.rd_o[0], 32'hDEADBEEF);
        tick();
        bus.wen_i = '0;
        #1;
        check("hold_r5", bus.rd_o[0], 32'hDEADBEEF);
        tick();
        tick();

        // Both ports to r7: port 1 wins, one-cycle conflict pulse.
        bus.wen_i = 2'b11;
        bus.wa_i  = {6'd7, 6'd7};
        bus.wd_i  = {32'h22, 32'h11};
        bus.ra_i  = {6'd0, 6'd7};
        #1;
        check("byp_prio_r7", bus.rd_o[0], 32'h22);
        tick();
        bus.wen_i = '0;
        #1;
        check("conf_pulse", W'(bus.wr_conflict_o), 32'd1);
        check("r7_winner", bus.rd_o[0], 32'h22);
        tick();
        check("conf_once", W'(bus.wr_conflict_o), 32'd0);

        // Writes to the zero entry are dropped and never conflict.
        bus.wen_i = 2'b11;
        bus.wa_i  = '0;
        bus.wd_i  = {32'hFFFFFFFF, 32'hFFFFFFFF};
        bus.ra_i  = '0;
        #1;
        check("r0_byp", bus.rd_o[0], 32'h0);
        tick();
        bus.wen_i = '0;
        #1;
        check("r0_conf", W'(bus.wr_conflict_o), 32'd0);
        check("r0_read", bus.rd_o[0], 32'h0);
        tick();

        // Fill r1..r10, then a requested clear with writes attempted while busy.
        for (int i = 0; i < 5; i++) begin
            bus.wen_i = 2'b11;
            bus.wa_i  = {AB'(2 * i + 2), AB'(2 * i + 1)};
            bus.wd_i  = {32'hA000_0000 | (2 * i + 2), 32'hA000_0000 | (2 * i + 1)};
            tick();
        end
        bus.wen_i = '0;
        bus.ra_i  = {6'd10, 6'd1};
        #1;
        check("fill_r1", bus.rd_o[0], 32'hA000_0001);
        check("fill_r10", bus.rd_o[1], 32'hA000_000A);
        bus.clr_i = 1'b1;
        tick();
        bus.clr_i = 1'b0;
        measure_busy("clr_busy_len");
        for (int i = 1; i <= 10; i++) begin
            bus.ra_i[0] = AB'(i);
            #1;
            check($sformatf("cleared_r%0d", i), bus.rd_o[0], 32'h0);
            tick();
        end

        // Reset ten cycles into a requested clear restarts the sequence.
        bus.clr_i = 1'b1;
        tick();
        bus.clr_i = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        measure_busy("rst_mid_clr_len");

        for (int i = 0; i < 400; i++) begin
            rand_inputs(1'b1);
            tick();
        end
        quiet();
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
        $finish;
    end

endmodule
